// File: rtl/video_line_fetch.sv
// Video-side SDRAM line fetcher: reads line_len 32-bit words (two 16-bit beats
// each) from a line base address into a small FIFO popped by pixel scan-out.
module video_line_fetch #(
  parameter int ADDR_W     = 25,
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base_addr,
  input  logic [LEN_W-1:0]  line_len,
  input  logic              pix_rd,
  output logic [31:0]       pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              line_done,
  output logic              busy,
  output logic [ADDR_W-1:0] sdram_vid_addr,
  output logic              sdram_vid_req,
  input  logic              sdram_vid_ack,
  input  logic              sdram_vid_ready,
  input  logic [15:0]       sdram_dout
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, CAP_HI} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              restart_pending;
  logic [15:0]       lo;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;
  logic [31:0]       push_word, head_nxt;
  logic [ADDR_W-1:0] base_aligned;

  // A flush on line_start overrides any push or pop in the same cycle.
  always_comb begin
    push         = (state == CAP_HI) && !restart_pending && !line_start;
    pop          = pix_rd && (count != '0) && !line_start;
    push_word    = {sdram_dout, lo};
    rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
    count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
    base_aligned = line_base_addr & ~ADDR_W'(3);
    // NOTE: head_nxt takes a default before the conditional so no latch is inferred.
    head_nxt     = pix_data;
    if (count_nxt != '0) begin
      if (count == CNT_W'(pop)) head_nxt = push_word;
      else                      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_data  <= '0;
      underflow <= 1'b0;
    end else if (line_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      pix_data <= head_nxt;
      if (pix_rd && (count == '0)) underflow <= 1'b1;
    end
  end

  assign pix_valid = (count != '0);
  assign busy      = (state != IDLE) || (remaining != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cur_addr        <= '0;
      remaining       <= '0;
      restart_pending <= 1'b0;
      lo              <= '0;
      line_done       <= 1'b0;
      sdram_vid_req   <= 1'b0;
      sdram_vid_addr  <= '0;
    end else begin
      if (line_start) begin
        cur_addr        <= base_aligned;
        remaining       <= line_len;
        line_done       <= (line_len == '0);
        // A read still in flight must finish but its data belongs to the old line.
        restart_pending <= (state == REQ) || (state == WAIT_DATA);
      end
      unique case (state)
        IDLE: begin
          if (!line_start && (remaining != '0) && (count < DEPTH) && !sdram_vid_ack) begin
            state          <= REQ;
            sdram_vid_req  <= 1'b1;
            sdram_vid_addr <= cur_addr;
          end
        end
        REQ: begin
          if (sdram_vid_ack) begin
            sdram_vid_req <= 1'b0;
            state         <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_vid_ready) begin
            lo    <= sdram_dout;
            state <= CAP_HI;
          end
        end
        CAP_HI: begin
          state <= IDLE;
          if (!line_start) begin
            restart_pending <= 1'b0;
            if (!restart_pending) begin
              cur_addr  <= cur_addr + ADDR_W'(4);
              remaining <= remaining - LEN_W'(1);
              line_done <= (remaining == LEN_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Self-checking bench for video_line_fetch: SDRAM controller model, a line-level
// scoreboard of expected words/addresses, and directed scenarios with literals.
module tb_video_line_fetch;
  localparam int ADDR_W = 25;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              line_start = 1'b0;
  logic [ADDR_W-1:0] line_base_addr = '0;
  logic [LEN_W-1:0]  line_len = '0;
  logic              pix_rd = 1'b0;
  logic [31:0]       pix_data;
  logic              pix_valid, underflow, line_done, busy;
  logic [ADDR_W-1:0] sdram_vid_addr;
  logic              sdram_vid_req;
  logic              sdram_vid_ack = 1'b0;
  logic              sdram_vid_ready = 1'b0;
  logic [15:0]       sdram_dout = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_line_fetch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start),
    .line_base_addr(line_base_addr), .line_len(line_len), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .line_done(line_done), .busy(busy), .sdram_vid_addr(sdram_vid_addr),
    .sdram_vid_req(sdram_vid_req), .sdram_vid_ack(sdram_vid_ack),
    .sdram_vid_ready(sdram_vid_ready), .sdram_dout(sdram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents seen through the controller: byte = 2*word_index + 0x20 + half.
  function automatic logic [15:0] beat(input logic [ADDR_W-1:0] a, input logic half);
    logic [7:0] b;
    b = 8'(a[9:2] * 2) + 8'h20 + 8'(half);
    return {b, b};
  endfunction

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    return {beat(a, 1'b1), beat(a, 1'b0)};
  endfunction

  // SDRAM controller model: ack one cycle, one idle cycle, then two data beats.
  logic [ADDR_W-1:0] ctl_addr;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset_n && sdram_vid_req) begin
        ctl_addr = sdram_vid_addr;
        sdram_vid_ack = 1'b1;
        @(posedge clk); #1;
        sdram_vid_ack = 1'b0;
        @(posedge clk); #1;
        sdram_vid_ready = 1'b1;
        sdram_dout = beat(ctl_addr, 1'b0);
        @(posedge clk); #1;
        sdram_dout = beat(ctl_addr, 1'b1);
        @(posedge clk); #1;
        sdram_vid_ready = 1'b0;
        sdram_dout = '0;
      end
    end
  end

  // Line-level model: the words a line must deliver, the addresses it must
  // request, and the sticky underflow flag; compared on every falling edge.
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] req_log[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                exp_rem = 0;
  int                req_count = 0;
  logic              prev_req = 1'b0;
  logic              exp_uf = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      req_log.delete();
      exp_rem   = 0;
      req_count = 0;
      prev_req  = 1'b0;
      exp_uf    = 1'b0;
    end else begin
      check("underflow", underflow, exp_uf);
      if (sdram_vid_req) check("addr_bit0", sdram_vid_addr[0], 0);
      if (sdram_vid_req && !prev_req) begin
        req_count++;
        req_log.push_back(sdram_vid_addr);
        if (exp_rem == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_req: got request at 0x%0h, expected none", sdram_vid_addr);
        end else begin
          check("req_addr", sdram_vid_addr, exp_addr);
          exp_addr = exp_addr + ADDR_W'(4);
          exp_rem--;
        end
      end
      prev_req = sdram_vid_req;
      if (line_start) begin
        exp_q.delete();
        req_log.delete();
        req_count = 0;
        exp_uf    = 1'b0;
        exp_addr  = line_base_addr & ~ADDR_W'(3);
        exp_rem   = int'(line_len);
        for (int i = 0; i < int'(line_len); i++)
          exp_q.push_back(word_at(exp_addr + ADDR_W'(4 * i)));
      end else begin
        if (pix_rd && !pix_valid) exp_uf = 1'b1;
        if (pix_rd && pix_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no data", pix_data);
          end else begin
            check("pop_data", pix_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_line(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input logic with_rd);
    @(posedge clk); #1;
    line_base_addr = base;
    line_len       = len;
    line_start     = 1'b1;
    pix_rd         = with_rd;
    @(posedge clk); #1;
    line_start = 1'b0;
    pix_rd     = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    @(posedge clk); #1;
    check({name, "_valid"}, pix_valid, 1);
    check(name, pix_data, exp);
    pix_rd = 1'b1;
    @(posedge clk); #1;
    pix_rd = 1'b0;
  endtask

  task automatic pop_any(input string name);
    @(posedge clk); #1;
    check({name, "_valid"}, pix_valid, 1);
    pix_rd = 1'b1;
    @(posedge clk); #1;
    pix_rd = 1'b0;
  endtask

  task automatic wait_line_done(input string name, input int budget);
    int n;
    n = 0;
    while (!line_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, line_done, 1);
  endtask

  task automatic wait_reqs(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (req_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, req_count, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_line_done"}, line_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req"}, sdram_vid_req, 0);
    check({tag, "_addr"}, sdram_vid_addr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Underflow on an empty FIFO, then line_start+pix_rd together with len=0.
    @(posedge clk); #1;
    pix_rd = 1'b1;
    @(posedge clk); #1;
    pix_rd = 1'b0;
    check("uf_set", underflow, 1);
    check("uf_valid", pix_valid, 0);
    check("uf_line_done_before", line_done, 0);
    start_line(25'h0, 9'd0, 1'b1);
    check("len0_uf_cleared", underflow, 0);
    check("len0_line_done", line_done, 1);
    check("len0_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("len0_no_req", req_count, 0);

    // Basic three-word line.
    start_line(25'h100, 9'd3, 1'b0);
    check("l3_busy", busy, 1);
    check("l3_not_done", line_done, 0);
    wait_line_done("l3_done", 200);
    check("l3_reqs", req_count, 3);
    repeat (20) @(negedge clk);
    check("l3_no_4th_req", req_count, 3);
    check("l3_idle", busy, 0);
    check("l3_addr0", req_log[0], 25'h100);
    check("l3_addr1", req_log[1], 25'h104);
    check("l3_addr2", req_log[2], 25'h108);
    pop_check("l3_w0", 32'hA1A1A0A0);
    pop_check("l3_w1", 32'hA3A3A2A2);
    pop_check("l3_w2", 32'hA5A5A4A4);
    check("l3_empty", pix_valid, 0);

    // FIFO back-pressure: 20 words into a 16-deep FIFO.
    start_line(25'h400, 9'd20, 1'b0);
    wait_reqs("full_16_reqs", 16, 400);
    repeat (40) @(negedge clk);
    check("full_stall_reqs", req_count, 16);
    check("full_req_low", sdram_vid_req, 0);
    check("full_not_done", line_done, 0);
    check("full_busy", busy, 1);
    for (int i = 0; i < 4; i++) pop_any("full_pop");
    wait_line_done("full_done", 300);
    check("full_total_reqs", req_count, 20);
    for (int i = 0; i < 16; i++) pop_any("full_drain");
    check("full_empty", pix_valid, 0);

    // Restart while the first read of a line is in WAIT_DATA.
    start_line(25'h100, 9'd3, 1'b0);
    n = 0;
    while (!sdram_vid_req && n < 50) begin @(negedge clk); n++; end
    while (sdram_vid_req && n < 50) begin @(negedge clk); n++; end
    check("rs_sync_in_budget", (n < 50), 1);
    start_line(25'h200, 9'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("rs_flushed", pix_valid, 0);
    wait_line_done("rs_done", 200);
    check("rs_reqs", req_count, 2);
    check("rs_addr0", req_log[0], 25'h200);
    check("rs_addr1", req_log[1], 25'h204);
    pop_check("rs_w0", 32'h21212020);
    pop_check("rs_w1", 32'h23232222);
    check("rs_empty", pix_valid, 0);

    // Address wrap at the top of the space, and low-bit masking.
    start_line(25'h1FFFFFC, 9'd2, 1'b0);
    wait_line_done("wrap_done", 200);
    check("wrap_reqs", req_count, 2);
    check("wrap_addr0", req_log[0], 25'h1FFFFFC);
    check("wrap_addr1", req_log[1], 25'h0);
    pop_any("wrap_pop");
    pop_any("wrap_pop");
    start_line(25'h103, 9'd1, 1'b0);
    wait_line_done("mask_done", 200);
    check("mask_addr", req_log[0], 25'h100);
    pop_check("mask_w0", 32'hA1A1A0A0);

    // Asynchronous reset in the middle of a line.
    start_line(25'h300, 9'd4, 1'b0);
    wait_reqs("rst_reqs", 2, 100);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_req", sdram_vid_req, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", pix_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
